// File: rtl/alu_bist.sv
// ALU built-in self-test sequencer.
// Steps through AND/OR/ADD/XOR/SLL/SUB/SRL in op-major, vector-minor order.
// For each vector it drives registered operands, waits ALU_LATENCY edges,
// then checks out/zero/ng (and overflow for ADD/SUB) against a golden model.
module alu_bist #(
    parameter int          VECTORS     = 8,
    parameter int          ALU_LATENCY = 1,
    parameter logic [31:0] SEED        = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  fail_count,
    output logic [3:0]  first_fail_op,
    output logic [5:0]  first_fail_vec,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [3:0]  alu_fn,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_ng,
    input  logic        alu_overflow
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'h0000_0001 : SEED;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] CORNER_X  = 32'h7FFF_FFFF;
    localparam logic [31:0] CORNER_Y  = 32'h0000_0001;
    localparam logic [31:0] Y_SALT    = 32'h5A5A_A5A5;
    localparam logic [5:0]  LAST_VEC  = 6'(VECTORS - 1);
    localparam logic [7:0]  LAST_WAIT = 8'(ALU_LATENCY);

    // Function code for each position in the test order.
    function automatic logic [3:0] op_code(input logic [2:0] idx);
        case (idx)
            3'd0:    op_code = 4'b0000;
            3'd1:    op_code = 4'b0001;
            3'd2:    op_code = 4'b0010;
            3'd3:    op_code = 4'b0011;
            3'd4:    op_code = 4'b0100;
            3'd5:    op_code = 4'b0110;
            3'd6:    op_code = 4'b1000;
            default: op_code = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] rotl13(input logic [31:0] v);
        rotl13 = {v[18:0], v[31:19]};
    endfunction

    state_t      state;
    logic [31:0] lfsr;
    logic [2:0]  op_idx;
    logic [5:0]  vec;
    logic [7:0]  wcnt;

    logic [31:0] sum, diff, exp_out, lfsr_nxt;
    logic        exp_ovf, chk_ovf, mismatch;
    logic        sample, vec_wrap, last;
    logic [2:0]  op_nxt;
    logic [5:0]  vec_nxt;
    logic [7:0]  fail_nxt;

    // Golden model evaluated on the held operands; valid at the sampling edge.
    always_comb begin
        sum     = alu_x + alu_y;
        diff    = alu_x - alu_y;
        exp_out = '0;
        exp_ovf = 1'b0;
        chk_ovf = 1'b0;
        case (alu_fn)
            4'b0000: exp_out = alu_x & alu_y;
            4'b0001: exp_out = alu_x | alu_y;
            4'b0011: exp_out = alu_x ^ alu_y;
            4'b0010: begin
                exp_out = sum;
                chk_ovf = 1'b1;
                exp_ovf = (alu_x[31] == alu_y[31]) && (sum[31] != alu_x[31]);
            end
            4'b0110: begin
                exp_out = diff;
                chk_ovf = 1'b1;
                exp_ovf = (alu_x[31] != alu_y[31]) && (diff[31] != alu_x[31]);
            end
            4'b0100: exp_out = alu_x << alu_y[4:0];
            4'b1000: exp_out = alu_x >> alu_y[4:0];
            default: exp_out = '0;
        endcase
        mismatch = (alu_out != exp_out) ||
                   (alu_zero != (exp_out == 32'd0)) ||
                   (alu_ng != exp_out[31]) ||
                   (chk_ovf && (alu_overflow != exp_ovf));
    end

    // Sequencing helpers: sample point, next op/vector, LFSR step, saturating count.
    always_comb begin
        sample   = (state == RUN) && (wcnt == LAST_WAIT);
        vec_wrap = (vec == LAST_VEC);
        last     = vec_wrap && (op_idx == 3'd6);
        op_nxt   = vec_wrap ? op_idx + 3'd1 : op_idx;
        vec_nxt  = vec_wrap ? 6'd0 : vec + 6'd1;
        lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);
        fail_nxt = (mismatch && (fail_count != 8'hFF)) ? fail_count + 8'd1 : fail_count;
    end

    // Control FSM with registered status and operand outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            lfsr           <= SEED_EFF;
            op_idx         <= '0;
            vec            <= '0;
            wcnt           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_op  <= '0;
            first_fail_vec <= '0;
            alu_x          <= '0;
            alu_y          <= '0;
            alu_fn         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        lfsr           <= SEED_EFF;
                        op_idx         <= '0;
                        vec            <= '0;
                        wcnt           <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail_count     <= '0;
                        first_fail_op  <= '0;
                        first_fail_vec <= '0;
                        alu_x          <= CORNER_X;
                        alu_y          <= CORNER_Y;
                        alu_fn         <= op_code(3'd0);
                    end
                end
                RUN: begin
                    if (!sample) begin
                        wcnt <= wcnt + 8'd1;
                    end else begin
                        wcnt       <= '0;
                        lfsr       <= lfsr_nxt;
                        fail_count <= fail_nxt;
                        if (mismatch && (fail_count == 8'd0)) begin
                            first_fail_op  <= alu_fn;
                            first_fail_vec <= vec;
                        end
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_nxt == 8'd0);
                        end else begin
                            // Launch the next vector; x follows the LFSR value
                            // that is current while the vector is presented.
                            op_idx <= op_nxt;
                            vec    <= vec_nxt;
                            alu_fn <= op_code(op_nxt);
                            if (vec_nxt == 6'd0) begin
                                alu_x <= CORNER_X;
                                alu_y <= CORNER_Y;
                            end else begin
                                alu_x <= lfsr_nxt;
                                alu_y <= rotl13(lfsr_nxt) ^ Y_SALT;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Scoreboard bench for alu_bist: two instances (registered ALU, latency 1,
// 4 vectors; combinational ALU, latency 0, 64 vectors) driven by a bench ALU
// with selectable faults. Expected reports are computed up front and queued.
module tb_alu_bist;

    localparam logic [31:0] SEED = 32'hACE1_2024;
    localparam logic [31:0] MASK = 32'h8020_0003;

    typedef struct packed {
        logic [31:0] out;
        logic        z;
        logic        n;
        logic        v;
    } resp_t;

    typedef struct {
        int fc;
        int fop;
        int fvec;
        int pass;
        int lat;
    } rep_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // fault modes: 0 good, 1 SUB computes ADD, 2 ADD overflow stuck 0,
    // 3 all outputs stuck 0, 4 single bit flip on one chosen vector
    int          mode1 = 0, mode2 = 0;
    logic [3:0]  bad_fn = '0;
    logic [31:0] bad_x = '0, bad_y = '0;
    int          bad_bit = 0;

    function automatic resp_t alu_ref(input logic [3:0] fn, input logic [31:0] x,
                                      input logic [31:0] y, input int mode);
        resp_t r;
        longint s;
        logic [3:0] f;
        f = fn;
        if (mode == 1 && fn == 4'b0110) f = 4'b0010;
        r.v = 1'b0;
        case (f)
            4'b0000: r.out = x & y;
            4'b0001: r.out = x | y;
            4'b0011: r.out = x ^ y;
            4'b0010: begin
                s = longint'($signed(x)) + longint'($signed(y));
                r.out = s[31:0];
                r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s = longint'($signed(x)) - longint'($signed(y));
                r.out = s[31:0];
                r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0100: r.out = x << y[4:0];
            4'b1000: r.out = x >> y[4:0];
            default: r.out = '0;
        endcase
        if (mode == 2 && fn == 4'b0010) r.v = 1'b0;
        if (mode == 4 && fn == bad_fn && x == bad_x && y == bad_y)
            r.out = r.out ^ (32'd1 << bad_bit);
        if (mode == 3) r.out = '0;
        r.z = (r.out == 32'd0);
        r.n = r.out[31];
        if (mode == 3) r.v = 1'b0;
        return r;
    endfunction

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- DUT 1: 4 vectors, registered ALU ----------------
    logic        start1 = 1'b0, busy1, done1, pass1;
    logic [7:0]  fc1;
    logic [3:0]  fop1, fn1;
    logic [5:0]  fvec1;
    logic [31:0] x1, y1;
    resp_t       r1;

    alu_bist #(.VECTORS(4), .ALU_LATENCY(1), .SEED(SEED)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_count(fc1), .first_fail_op(fop1), .first_fail_vec(fvec1),
        .alu_x(x1), .alu_y(y1), .alu_fn(fn1),
        .alu_out(r1.out), .alu_zero(r1.z), .alu_ng(r1.n), .alu_overflow(r1.v)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) r1 <= '0;
        else        r1 <= alu_ref(fn1, x1, y1, mode1);

    // ---------------- DUT 2: 64 vectors, combinational ALU ----------------
    logic        start2 = 1'b0, busy2, done2, pass2;
    logic [7:0]  fc2;
    logic [3:0]  fop2, fn2;
    logic [5:0]  fvec2;
    logic [31:0] x2, y2;
    resp_t       r2;

    assign r2 = alu_ref(fn2, x2, y2, mode2);

    alu_bist #(.VECTORS(64), .ALU_LATENCY(0), .SEED(SEED)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .pass(pass2), .fail_count(fc2), .first_fail_op(fop2), .first_fail_vec(fvec2),
        .alu_x(x2), .alu_y(y2), .alu_fn(fn2),
        .alu_out(r2.out), .alu_zero(r2.z), .alu_ng(r2.n), .alu_overflow(r2.v)
    );

    // ---------------- reference model ----------------
    logic [3:0]  exp_fn[448];
    logic [31:0] exp_x[448], exp_y[448];
    rep_t        q1[$], q2[$];
    int          c0_1 = 0, c0_2 = 0;

    // Walk the whole run at vector level and record operands plus expected report.
    task automatic build(input int nv, input int lat, input int mode, output rep_t e);
        logic [3:0]  ops[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b1000};
        logic [31:0] l, x, y;
        resp_t       g, a;
        int          j;
        logic        bad;
        l = SEED;
        j = 0;
        e.fc = 0; e.fop = 0; e.fvec = 0;
        for (int op = 0; op < 7; op++) begin
            for (int v = 0; v < nv; v++) begin
                if (v == 0) begin
                    x = 32'h7FFF_FFFF;
                    y = 32'h0000_0001;
                end else begin
                    x = l;
                    y = ((l << 13) | (l >> 19)) ^ 32'h5A5A_A5A5;
                end
                exp_fn[j] = ops[op]; exp_x[j] = x; exp_y[j] = y;
                g = alu_ref(ops[op], x, y, 0);
                a = alu_ref(ops[op], x, y, mode);
                bad = (g.out != a.out) || (g.z != a.z) || (g.n != a.n) ||
                      ((ops[op] == 4'b0010 || ops[op] == 4'b0110) && (g.v != a.v));
                if (bad) begin
                    if (e.fc == 0) begin e.fop = int'(ops[op]); e.fvec = v; end
                    if (e.fc < 255) e.fc++;
                end
                l = l[0] ? ((l >> 1) ^ MASK) : (l >> 1);
                j++;
            end
        end
        e.pass = (e.fc == 0) ? 1 : 0;
        e.lat  = 7 * nv * (lat + 1);
    endtask

    // ---------------- monitors ----------------
    logic done1_q = 1'b0, done2_q = 1'b0;

    // Report check on every rising done, plus operand check at each vector start.
    always @(negedge clk) begin
        done1_q <= done1;
        done2_q <= done2;
        if (busy1 && ((cyc - c0_1) % 2 == 0) && ((cyc - c0_1) / 2 < 28)) begin
            chk("d1_fn",  fn1, exp_fn[(cyc - c0_1) / 2]);
            chk("d1_x",   x1,  exp_x[(cyc - c0_1) / 2]);
            chk("d1_y",   y1,  exp_y[(cyc - c0_1) / 2]);
        end
        if (done1 && !done1_q) begin
            if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
            else begin
                chk("d1_done_latency", cyc - c0_1, q1[0].lat);
                chk("d1_fail_count", fc1, q1[0].fc);
                chk("d1_first_fail_op", fop1, q1[0].fop);
                chk("d1_first_fail_vec", fvec1, q1[0].fvec);
                chk("d1_pass", pass1, q1[0].pass);
                chk("d1_busy_at_done", busy1, 0);
                void'(q1.pop_front());
            end
        end
        if (done2 && !done2_q) begin
            if (q2.size() == 0) chk("d2_unexpected_done", 1, 0);
            else begin
                chk("d2_done_latency", cyc - c0_2, q2[0].lat);
                chk("d2_fail_count", fc2, q2[0].fc);
                chk("d2_first_fail_op", fop2, q2[0].fop);
                chk("d2_first_fail_vec", fvec2, q2[0].fvec);
                chk("d2_pass", pass2, q2[0].pass);
                void'(q2.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch1(input int mode);
        rep_t e;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        @(negedge clk);
        mode1 = mode;
        build(4, 1, mode, e);
        q1.push_back(e);
        start1 = 1'b1;
        @(posedge clk);
        #1 c0_1 = cyc;
        start1 = 1'b0;
    endtask

    task automatic launch2(input int mode);
        rep_t e;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        @(negedge clk);
        mode2 = mode;
        build(64, 0, mode, e);
        q2.push_back(e);
        start2 = 1'b1;
        @(posedge clk);
        #1 c0_2 = cyc;
        start2 = 1'b0;
    endtask

    task automatic drain(input int id, input int budget);
        int n = 0;
        while (((id == 1) ? q1.size() : q2.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (((id == 1) ? q1.size() : q2.size()) != 0) begin
            chk("drain_timeout", n, budget - 1);
            if (id == 1) q1.delete(); else q2.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pick_bitflip();
        rep_t e;
        int   j;
        build(4, 1, 0, e);
        j = $urandom_range(0, 6) * 4 + $urandom_range(1, 3);
        bad_fn  = exp_fn[j];
        bad_x   = exp_x[j];
        bad_y   = exp_y[j];
        bad_bit = $urandom_range(0, 31);
    endtask

    initial begin
        // reset state
        #23;
        chk("rst_busy", busy1, 0);  chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);  chk("rst_fc", fc1, 0);
        chk("rst_fop", fop1, 0);    chk("rst_fvec", fvec1, 0);
        chk("rst_x", x1, 0);        chk("rst_y", y1, 0);
        chk("rst_fn", fn1, 0);      chk("rst2_x", x2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // good ALU with a start re-pulse mid-run that must be ignored
        launch1(0);
        while (cyc - c0_1 < 10) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        drain(1, 200);
        chk("hold_fn_after_done", fn1, 4'b1000);
        chk("hold_x_after_done", x1, exp_x[27]);

        // fault modes: SUB as ADD, ADD overflow lost, random bit flips
        launch1(1); drain(1, 200);
        launch1(2); drain(1, 200);
        for (int k = 0; k < 3; k++) begin
            pick_bitflip();
            launch1(4); drain(1, 200);
        end

        // async reset mid-run aborts without a report
        launch1(0);
        while (cyc - c0_1 < 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy1, 0); chk("abort_done", done1, 0);
        chk("abort_fc", fc1, 0);     chk("abort_x", x1, 0);
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        launch1(0); drain(1, 200);

        // combinational ALU, 64 vectors: clean run then stuck-at-zero saturation
        launch2(0); drain(2, 1000);
        launch2(3); drain(2, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Synthesizable built-in self-test sequencer that sits on the driving side of the ALU operand/function interface.
- Drives x/y/ALUFn into the ALU for every supported function code and samples out/zero/ng/overflow.
- Compares each sampled result against an internal golden model and reports the pass/fail summary to the core debug/status logic.
- Used at power-up and on demand.

Parameters:
- VECTORS, 8, vectors per function code (1..64).
- ALU_LATENCY, 1, clock edges from operands valid to ALU result valid (0 = combinational ALU).
- SEED, 32'hACE1_2024, LFSR start value; a value of 0 is replaced by 32'h0000_0001.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request, sampled in IDLE/DONE only
- busy  out  1  run in progress
- done  out  1  run complete, held until next start
- pass  out  1  done && fail_count==0
- fail_count  out  8  mismatching vectors, saturates at 255
- first_fail_op  out  4  ALUFn of first mismatch (0 if none)
- first_fail_vec  out  6  vector index of first mismatch (0 if none)
- alu_x  out  32  ALU operand x
- alu_y  out  32  ALU operand y
- alu_fn  out  4  ALUFn
- alu_out  in  32  ALU result
- alu_zero  in  1  ALU zero flag
- alu_ng  in  1  ALU negative flag
- alu_overflow  in  1  ALU signed overflow flag

Behaviour:
- Reset (async, any state): all outputs 0; FSM enters IDLE; LFSR loads SEED.
- Op order: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SUB 0110, SRL 1000. Runs op-major, vector-minor.
- States:
  - IDLE/DONE: on start=1, clear fail_count, first_fail_*, and done; load LFSR; set op index 0, vector 0; go to RUN.
  - RUN: per-vector counter wait runs 0..ALU_LATENCY.
  - DONE: busy=0, done=1.
- Operands are registered and change only on the edge that begins a vector. They are held stable until the sampling edge.
  - Vector 0 of every op: x=32'h7FFF_FFFF, y=32'h0000_0001.
  - Vector k>0: x=lfsr; y=rotl(lfsr,13)^32'h5A5A_A5A5.
- LFSR: Galois, right shift, mask 32'h8020_0003. It advances once on every sampling edge.
- Sampling edge: the edge ending cycle T+ALU_LATENCY, where T is the first cycle the operands are valid. On that edge, compare and launch the next vector.
- Each vector therefore takes ALU_LATENCY+1 cycles.
- Golden model, all arithmetic 32-bit wrap:
  - ADD = x+y. SUB = x−y.
  - SLL = x<<y[4:0]. SRL = x>>y[4:0] (logical).
  - exp_zero = (exp_out==0). exp_ng = exp_out[31].
  - exp_ovf for ADD: sign(x)==sign(y) && sign(res)!=sign(x).
  - exp_ovf for SUB: sign(x)!=sign(y) && sign(res)!=sign(x).
  - alu_overflow is compared only for ADD/SUB and ignored otherwise.
- Mismatch (any compared field differs):
  - fail_count increments, saturating at 255.
  - If this is the first mismatch of the run, latch first_fail_op and first_fail_vec.
- After the last sample (op 6, vector VECTORS−1): go to DONE. done=1 and busy=0 from that edge.
  - With start sampled at edge E0, done rises at edge E0 + 7·VECTORS·(ALU_LATENCY+1).
- busy=1 exactly while in RUN. start while busy is ignored.
- start in DONE restarts the run. The LFSR reloads SEED, so the run is repeatable.
- alu_fn/alu_x/alu_y hold their last values in IDLE/DONE; they are 0 only after reset.
- Reset mid-run aborts immediately with no report. The next start begins from op 0, vector 0.

Test Plan:
- Correct 1-cycle ALU model, VECTORS=4, ALU_LATENCY=1, start pulse → done rises exactly 56 cycles after start edge; pass=1, fail_count=0, first_fail_op=0.
- ALU model with SUB returning x+y → fail_count=4, first_fail_op=4'b0110, first_fail_vec=0, pass=0.
- Correct ALU; check corner vector 0 of ADD (x=7FFFFFFF, y=1) → alu_out=80000000, ng=1, overflow=1 accepted; overflow forced to 0 on ADD only → fail_count=1, first_fail_vec=0.
- Combinational ALU with ALU_LATENCY=0, VECTORS=2 → done after 14 cycles, pass=1. The same ALU registered but ALU_LATENCY=0 → fail_count>0.
- start re-pulsed at cycle 10 of a run → ignored, done timing unchanged. rst_n low at cycle 20 → busy/done/fail_count/alu_x=0 asynchronously. New start → full run, pass=1.
- VECTORS=64, ALU output stuck at 0 → fail_count saturates at 255, first_fail_op=4'b0000, first_fail_vec=0 (AND of 7FFFFFFF/1 is nonzero), done asserted after 448·(ALU_LATENCY+1) cycles.
